spmm_job_sequencer: RTL and testbench

Control FSM for one SpMM job on the N-PE sparse matrix-multiply datapath. It accepts the RHS matrix in 4-row beats, then waits for an LHS CSR tile. It sequences the PE row pipeline and capture of PE results into the output buffer, then streams the results out in 4-row beats. It owns every external ready/start handshake and drives the datapath write, start and capture strobes; it holds no data.

---
 rtl/spmm_job_sequencer.sv | 163 ++++++++++++++++
 tb/tb_spmm_job_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/spmm_job_sequencer.sv
// Job-level control FSM for the N-PE SpMM datapath: RHS load, LHS launch,
// PE row sequencing with result capture, and blockwise output streaming.
module spmm_job_sequencer #(
  parameter int N        = 16,
  parameter int PE_DELAY = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     abort,
  output logic                     rhs_ready,
  input  logic                     rhs_start,
  output logic                     lhs_ready_ns,
  output logic                     lhs_ready_ws,
  input  logic                     lhs_start,
  input  logic                     lhs_ws,
  output logic                     out_ready,
  input  logic                     out_start,
  output logic                     rhs_wr_en,
  output logic [$clog2(N/4)-1:0]   rhs_wr_blk,
  output logic                     pe_start,
  output logic [$clog2(N)-1:0]     pe_row,
  output logic                     cap_en,
  output logic [$clog2(N)-1:0]     cap_row,
  output logic [$clog2(N/4)-1:0]   out_blk,
  output logic                     busy,
  output logic                     done
);

  localparam int BW = $clog2(N/4);
  localparam int RW = $clog2(N);
  localparam int CW = $clog2(N + PE_DELAY);

  localparam logic [BW-1:0] LAST_BLK = BW'(N/4 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N + PE_DELAY - 1);
  localparam logic [CW-1:0] PD_CNT   = CW'(PE_DELAY);
  localparam logic [CW-1:0] N_CNT    = CW'(N);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_RHS,
    WAIT_LHS,
    PROCESS,
    OUTPUT
  } state_t;

  state_t          state, state_n;
  logic            rhs_loaded, rhs_loaded_n;
  logic [BW-1:0]   rhs_blk, rhs_blk_n;
  logic [CW-1:0]   proc_cnt, proc_cnt_n;
  logic [BW-1:0]   out_blk_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rhs_loaded <= 1'b0;
      rhs_blk    <= '0;
      proc_cnt   <= '0;
      out_blk    <= '0;
    end else begin
      state      <= state_n;
      rhs_loaded <= rhs_loaded_n;
      rhs_blk    <= rhs_blk_n;
      proc_cnt   <= proc_cnt_n;
      out_blk    <= out_blk_n;
    end
  end

  always_comb begin
    state_n      = state;
    rhs_loaded_n = rhs_loaded;
    rhs_blk_n    = rhs_blk;
    proc_cnt_n   = proc_cnt;
    out_blk_n    = out_blk;
    rhs_ready    = 1'b0;
    lhs_ready_ns = 1'b0;
    lhs_ready_ws = 1'b0;
    out_ready    = 1'b0;
    rhs_wr_en    = 1'b0;
    pe_start     = 1'b0;
    cap_en       = 1'b0;
    done         = 1'b0;

    case (state)
      IDLE: begin
        rhs_ready    = 1'b1;
        lhs_ready_ws = rhs_loaded;
        // A fresh RHS beat takes priority over a warm-start LHS in the same cycle
        if (!abort && rhs_start) begin
          rhs_wr_en    = 1'b1;
          rhs_loaded_n = 1'b0;
          rhs_blk_n    = BW'(1);
          state_n      = LOAD_RHS;
        end else if (!abort && lhs_start && lhs_ws && rhs_loaded) begin
          pe_start   = 1'b1;
          proc_cnt_n = '0;
          state_n    = PROCESS;
        end
      end
      LOAD_RHS: begin
        rhs_ready = 1'b1;
        if (!abort && rhs_start) begin
          rhs_wr_en = 1'b1;
          if (rhs_blk == LAST_BLK) begin
            rhs_loaded_n = 1'b1;
            rhs_blk_n    = '0;
            state_n      = WAIT_LHS;
          end else begin
            rhs_blk_n = rhs_blk + BW'(1);
          end
        end
      end
      WAIT_LHS: begin
        lhs_ready_ns = 1'b1;
        if (!abort && lhs_start) begin
          pe_start   = 1'b1;
          proc_cnt_n = '0;
          state_n    = PROCESS;
        end
      end
      PROCESS: begin
        cap_en = !abort && (proc_cnt >= PD_CNT);
        if (proc_cnt == LAST_CNT) begin
          proc_cnt_n = '0;
          out_blk_n  = '0;
          state_n    = OUTPUT;
        end else begin
          proc_cnt_n = proc_cnt + CW'(1);
        end
      end
      OUTPUT: begin
        out_ready = 1'b1;
        if (!abort && out_start) begin
          if (out_blk == LAST_BLK) begin
            done      = 1'b1;
            out_blk_n = '0;
            state_n   = IDLE;
          end else begin
            out_blk_n = out_blk + BW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Abort keeps a completed RHS load resident, but not a partial one
    if (abort) begin
      state_n    = IDLE;
      rhs_blk_n  = '0;
      proc_cnt_n = '0;
      out_blk_n  = '0;
      if (state == LOAD_RHS) rhs_loaded_n = 1'b0;
    end
  end

  always_comb begin
    pe_row  = (proc_cnt < N_CNT) ? RW'(proc_cnt) : RW'(N - 1);
    cap_row = cap_en ? RW'(proc_cnt - PD_CNT) : '0;
  end

  assign rhs_wr_blk = rhs_blk;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_spmm_job_sequencer.sv
// Directed vector bench for spmm_job_sequencer (N=16, PE_DELAY=2).
module tb_spmm_job_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       abort = 1'b0;
  logic       rhs_start = 1'b0, lhs_start = 1'b0, lhs_ws = 1'b0, out_start = 1'b0;
  logic       rhs_ready, lhs_ready_ns, lhs_ready_ws, out_ready;
  logic       rhs_wr_en, pe_start, cap_en, busy, done;
  logic [1:0] rhs_wr_blk, out_blk;
  logic [3:0] pe_row, cap_row;

  typedef struct packed {
    logic ab, rs, ls, ws, os;
  } in_t;

  typedef struct packed {
    logic       rr, lrn, lrw, we;
    logic [1:0] wb;
    logic       ps, ce;
    logic [3:0] pr, cr;
    logic       ordy;
    logic [1:0] ob;
    logic       dn, bz;
  } outs_t;

  typedef struct {
    in_t   in;
    outs_t exp;
    string name;
  } vec_t;

  vec_t  vecs[$];
  outs_t act;
  int    checks = 0;
  int    failures = 0;
  int    split;

  always #5 clock = ~clock;

  spmm_job_sequencer #(.N(16), .PE_DELAY(2)) dut (
    .clock(clock), .reset(reset), .abort(abort),
    .rhs_ready(rhs_ready), .rhs_start(rhs_start),
    .lhs_ready_ns(lhs_ready_ns), .lhs_ready_ws(lhs_ready_ws),
    .lhs_start(lhs_start), .lhs_ws(lhs_ws),
    .out_ready(out_ready), .out_start(out_start),
    .rhs_wr_en(rhs_wr_en), .rhs_wr_blk(rhs_wr_blk),
    .pe_start(pe_start), .pe_row(pe_row),
    .cap_en(cap_en), .cap_row(cap_row),
    .out_blk(out_blk), .busy(busy), .done(done)
  );

  assign act = {rhs_ready, lhs_ready_ns, lhs_ready_ws, rhs_wr_en, rhs_wr_blk,
                pe_start, cap_en, pe_row, cap_row, out_ready, out_blk, done, busy};

  function automatic in_t vin(int ab, int rs, int ls, int ws, int os);
    in_t v;
    v.ab = ab[0]; v.rs = rs[0]; v.ls = ls[0]; v.ws = ws[0]; v.os = os[0];
    return v;
  endfunction

  function automatic outs_t vout(int rr, int lrn, int lrw, int we, int wb, int ps,
                                 int ce, int pr, int cr, int ordy, int ob, int dn, int bz);
    outs_t o;
    o.rr = rr[0]; o.lrn = lrn[0]; o.lrw = lrw[0]; o.we = we[0]; o.wb = wb[1:0];
    o.ps = ps[0]; o.ce = ce[0]; o.pr = pr[3:0]; o.cr = cr[3:0];
    o.ordy = ordy[0]; o.ob = ob[1:0]; o.dn = dn[0]; o.bz = bz[0];
    return o;
  endfunction

  function automatic void add(in_t in, outs_t exp, string name);
    vec_t v;
    v.in = in; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endfunction

  // PROCESS phase: stray rhs/lhs/out starts are driven on some cycles and must be ignored
  function automatic void add_proc(int n, int abort_at, string tag);
    for (int k = 0; k < n; k++) begin
      int ab = (k == abort_at) ? 1 : 0;
      int ce = (k >= 2 && ab == 0) ? 1 : 0;
      int cr = (ce == 1) ? k - 2 : 0;
      int pr = (k < 16) ? k : 15;
      add(vin(ab, k % 2, k % 2, 1, (k % 3 == 0) ? 1 : 0),
          vout(0, 0, 0, 0, 0, 0, ce, pr, cr, 0, 0, 0, 1),
          $sformatf("%s_%0d", tag, k));
    end
  endfunction

  task automatic check(string name, outs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic apply(int lo, int hi);
    for (int k = lo; k < hi; k++) begin
      @(negedge clock);
      abort = vecs[k].in.ab; rhs_start = vecs[k].in.rs; lhs_start = vecs[k].in.ls;
      lhs_ws = vecs[k].in.ws; out_start = vecs[k].in.os;
      #1 check(vecs[k].name, vecs[k].exp);
    end
  endtask

  initial begin
    // Cold start: reset state, unloaded warm start ignored, 4 RHS beats with one stall
    add(vin(0,0,0,0,0), vout(1,0,0,0,0,0,0,0,0,0,0,0,0), "reset_idle");
    add(vin(0,0,1,1,0), vout(1,0,0,0,0,0,0,0,0,0,0,0,0), "ws_unloaded");
    add(vin(0,0,0,0,1), vout(1,0,0,0,0,0,0,0,0,0,0,0,0), "idle_out_ign");
    add(vin(0,1,0,0,0), vout(1,0,0,1,0,0,0,0,0,0,0,0,0), "rhs_blk0");
    add(vin(0,1,0,0,0), vout(1,0,0,1,1,0,0,0,0,0,0,0,1), "rhs_blk1");
    add(vin(0,0,0,0,0), vout(1,0,0,0,2,0,0,0,0,0,0,0,1), "rhs_stall");
    add(vin(0,1,0,0,0), vout(1,0,0,1,2,0,0,0,0,0,0,0,1), "rhs_blk2");
    add(vin(0,1,0,0,0), vout(1,0,0,1,3,0,0,0,0,0,0,0,1), "rhs_blk3");
    add(vin(0,1,0,0,1), vout(0,1,0,0,0,0,0,0,0,0,0,0,1), "wait_ign");
    add(vin(0,0,1,0,0), vout(0,1,0,0,0,1,0,0,0,0,0,0,1), "lhs_ns");
    add_proc(18, -1, "proc");
    // Output with gaps; stray starts in the gaps
    add(vin(0,0,0,0,1), vout(0,0,0,0,0,0,0,0,0,1,0,0,1), "out_acc0");
    add(vin(0,1,1,1,0), vout(0,0,0,0,0,0,0,0,0,1,1,0,1), "out_gap1");
    add(vin(0,0,0,0,1), vout(0,0,0,0,0,0,0,0,0,1,1,0,1), "out_acc1");
    add(vin(0,0,0,0,1), vout(0,0,0,0,0,0,0,0,0,1,2,0,1), "out_acc2");
    add(vin(0,1,1,0,0), vout(0,0,0,0,0,0,0,0,0,1,3,0,1), "out_gap4");
    add(vin(0,0,0,0,1), vout(0,0,0,0,0,0,0,0,0,1,3,1,1), "out_done");
    add(vin(0,0,0,0,0), vout(1,0,1,0,0,0,0,0,0,0,0,0,0), "idle_loaded");
    // Warm start, then abort in PROCESS keeps the resident RHS
    add(vin(0,0,1,1,0), vout(1,0,1,0,0,1,0,0,0,0,0,0,0), "lhs_ws");
    add_proc(4, 3, "proc_abort");
    add(vin(0,0,0,0,0), vout(1,0,1,0,0,0,0,0,0,0,0,0,0), "abort_keep");
    // Simultaneous RHS and LHS in IDLE: RHS wins; then abort the partial load
    add(vin(0,1,1,1,0), vout(1,0,1,1,0,0,0,0,0,0,0,0,0), "rhs_wins");
    add(vin(0,1,0,0,0), vout(1,0,0,1,1,0,0,0,0,0,0,0,1), "rhs2_blk1");
    add(vin(1,1,0,0,0), vout(1,0,0,0,2,0,0,0,0,0,0,0,1), "abort_load");
    add(vin(0,0,0,0,0), vout(1,0,0,0,0,0,0,0,0,0,0,0,0), "abort_clr");
    add(vin(0,0,1,1,0), vout(1,0,0,0,0,0,0,0,0,0,0,0,0), "ws_after_abort");
    // Another job up to OUTPUT for the mid-job reset
    add(vin(0,1,0,0,0), vout(1,0,0,1,0,0,0,0,0,0,0,0,0), "j3_blk0");
    add(vin(0,1,0,0,0), vout(1,0,0,1,1,0,0,0,0,0,0,0,1), "j3_blk1");
    add(vin(0,1,0,0,0), vout(1,0,0,1,2,0,0,0,0,0,0,0,1), "j3_blk2");
    add(vin(0,1,0,0,0), vout(1,0,0,1,3,0,0,0,0,0,0,0,1), "j3_blk3");
    add(vin(0,0,1,1,0), vout(0,1,0,0,0,1,0,0,0,0,0,0,1), "j3_lhs");
    add_proc(18, -1, "j3_proc");
    add(vin(0,0,0,0,1), vout(0,0,0,0,0,0,0,0,0,1,0,0,1), "j3_out0");
    split = vecs.size();
    // After the asynchronous reset the RHS is gone
    add(vin(0,0,1,1,0), vout(1,0,0,0,0,0,0,0,0,0,0,0,0), "post_rst_ws");
    add(vin(0,0,0,0,0), vout(1,0,0,0,0,0,0,0,0,0,0,0,0), "post_rst_idle");

    repeat (2) @(negedge clock);
    reset = 1'b0;
    apply(0, split);

    @(negedge clock);
    abort = 1'b0; rhs_start = 1'b0; lhs_start = 1'b0; lhs_ws = 1'b0; out_start = 1'b0;
    #1 check("pre_reset", vout(0,0,0,0,0,0,0,0,0,1,1,0,1));
    reset = 1'b1;
    #1 check("async_reset", vout(1,0,0,0,0,0,0,0,0,0,0,0,0));
    @(negedge clock);
    reset = 1'b0;
    apply(split, vecs.size());

    @(negedge clock);
    abort = 1'b0; rhs_start = 1'b0; lhs_start = 1'b0; lhs_ws = 1'b0; out_start = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
